// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
//   Pays out a change amount through the coin hopper, one coin per handshake.
//   Denominations are chosen greedily (20c, then 10c, then 5c). Any residue
//   below 5c cannot be paid and is flagged with short_pay when the payout ends.
//   If the hopper does not confirm a coin within TIMEOUT_CYC cycles, the block
//   parks in a fault state until clear_fault is asserted.
//
// Parameters
//   TIMEOUT_CYC  cycles allowed from an eject pulse to coin_ack
//   AMT_W        width of the change amount and the remaining counter
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   change_valid payout request, sampled only while idle
//   change_amt   amount to pay out, cents
//   hopper_ready hopper can accept an eject command
//   coin_ack     one-cycle pulse, hopper saw the ejected coin leave
//   clear_fault  leave the fault state and return to idle
//   eject_20/10/5 one-cycle eject command for one coin of that value
//   busy         high whenever not idle
//   done         one-cycle pulse at the end of a payout
//   short_pay    qualifies done: a residue of 1..4c was left unpaid
//   error        high while in the fault state
//   remaining    change still owed (registered)
// -----------------------------------------------------------------------------
module change_dispenser #(
  parameter int TIMEOUT_CYC = 1000,
  parameter int AMT_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             change_valid,
  input  logic [AMT_W-1:0] change_amt,
  input  logic             hopper_ready,
  input  logic             coin_ack,
  input  logic             clear_fault,
  output logic             eject_20,
  output logic             eject_10,
  output logic             eject_5,
  output logic             busy,
  output logic             done,
  output logic             short_pay,
  output logic             error,
  output logic [AMT_W-1:0] remaining
);

  // The timer only has to reach TIMEOUT_CYC-1.
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_EJECT,
    S_WAIT_ACK,
    S_DONE,
    S_FAULT
  } state_t;

  typedef enum logic [1:0] {
    C_NONE,
    C_20,
    C_10,
    C_5
  } coin_t;

  state_t           state, state_next;
  coin_t            coin, coin_next;
  logic [AMT_W-1:0] remaining_q, remaining_next;
  logic [TMR_W-1:0] timer, timer_next;

  // Greedy pick from the current amount owed. A coin is only ever picked when
  // remaining covers it, so the later subtraction cannot underflow.
  coin_t            pick;
  logic [AMT_W-1:0] coin_value;

  always_comb begin
    if (remaining_q >= AMT_W'(20))      pick = C_20;
    else if (remaining_q >= AMT_W'(10)) pick = C_10;
    else if (remaining_q >= AMT_W'(5))  pick = C_5;
    else                                pick = C_NONE;
  end

  always_comb begin
    case (coin)
      C_20:    coin_value = AMT_W'(20);
      C_10:    coin_value = AMT_W'(10);
      C_5:     coin_value = AMT_W'(5);
      default: coin_value = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      coin        <= C_NONE;
      remaining_q <= '0;
      timer       <= '0;
    end else begin
      state       <= state_next;
      coin        <= coin_next;
      remaining_q <= remaining_next;
      timer       <= timer_next;
    end
  end

  always_comb begin
    state_next     = state;
    coin_next      = coin;
    remaining_next = remaining_q;
    timer_next     = timer;

    case (state)
      S_IDLE: begin
        if (change_valid) begin
          remaining_next = change_amt;
          state_next     = S_SELECT;
        end
      end

      S_SELECT: begin
        // Waiting on hopper_ready is not subject to the ack timeout.
        if (pick == C_NONE) begin
          state_next = S_DONE;
        end else if (hopper_ready) begin
          coin_next  = pick;
          state_next = S_EJECT;
        end
      end

      S_EJECT: begin
        timer_next = '0;
        state_next = S_WAIT_ACK;
      end

      S_WAIT_ACK: begin
        // An ack arriving on the last allowed cycle still counts.
        if (coin_ack) begin
          remaining_next = remaining_q - coin_value;
          state_next     = S_SELECT;
        end else if (timer == TMR_LAST) begin
          state_next = S_FAULT;
        end else begin
          timer_next = timer + TMR_W'(1);
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      S_FAULT: begin
        if (clear_fault) state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // All outputs decode registered state only.
  assign eject_20  = (state == S_EJECT) && (coin == C_20);
  assign eject_10  = (state == S_EJECT) && (coin == C_10);
  assign eject_5   = (state == S_EJECT) && (coin == C_5);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign short_pay = (state == S_DONE) && (remaining_q != '0);
  assign error     = (state == S_FAULT);
  assign remaining = remaining_q;

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;

  localparam int AMT_W   = 8;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             change_valid = 1'b0;
  logic [AMT_W-1:0] change_amt = '0;
  logic             hopper_ready = 1'b0;
  logic             coin_ack = 1'b0;
  logic             clear_fault = 1'b0;
  logic             eject_20, eject_10, eject_5;
  logic             busy, done, short_pay, error;
  logic [AMT_W-1:0] remaining;

  int checks = 0;
  int errors = 0;

  // Results of the most recent payout, filled in by run_payout.
  int obs_q[$];
  int obs_cycles;
  bit obs_done;
  bit obs_sp;
  int obs_rem;

  always #5 clk = ~clk;

  change_dispenser #(.TIMEOUT_CYC(TIMEOUT), .AMT_W(AMT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .change_valid(change_valid), .change_amt(change_amt),
    .hopper_ready(hopper_ready), .coin_ack(coin_ack), .clear_fault(clear_fault),
    .eject_20(eject_20), .eject_10(eject_10), .eject_5(eject_5),
    .busy(busy), .done(done), .short_pay(short_pay), .error(error),
    .remaining(remaining)
  );

  // Hopper model: issues a request, acks every eject after 1..max_delay
  // cycles, optionally holds hopper_ready low for the first `stall` cycles,
  // and records coins seen until done. Inputs change and outputs are read on
  // the falling edge.
  task automatic run_payout(input int amt, input int max_delay, input int stall,
                            input bit rand_ready, input bit spurious_valid);
    int ack_cnt;
    @(negedge clk);
    change_valid = 1'b1;
    change_amt   = AMT_W'(amt);
    hopper_ready = (stall == 0);
    coin_ack     = 1'b0;
    obs_q.delete();
    obs_done   = 1'b0;
    obs_sp     = 1'b0;
    obs_rem    = -1;
    obs_cycles = 0;
    ack_cnt    = -1;
    for (int c = 0; c < 3000 && !obs_done; c++) begin
      @(negedge clk);
      obs_cycles++;
      change_valid = spurious_valid ? ($urandom % 3 == 0) : 1'b0;
      change_amt   = AMT_W'($urandom);
      coin_ack     = 1'b0;
      if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) begin
          coin_ack = 1'b1;
          ack_cnt  = -1;
        end
      end
      if (obs_cycles < stall) hopper_ready = 1'b0;
      else hopper_ready = rand_ready ? ($urandom % 3 != 0) : 1'b1;

      checks++;
      if ((32'(eject_20) + 32'(eject_10) + 32'(eject_5)) > 1 || error) begin
        errors++;
        $display("FAIL payout_sanity amt=%0d cycle=%0d: ej20=%b ej10=%b ej5=%b error=%b, required at most one eject and error=0",
                 amt, obs_cycles, eject_20, eject_10, eject_5, error);
      end
      if (eject_20) obs_q.push_back(20);
      if (eject_10) obs_q.push_back(10);
      if (eject_5)  obs_q.push_back(5);
      if (eject_20 || eject_10 || eject_5) ack_cnt = $urandom_range(1, max_delay);
      if (done) begin
        obs_done     = 1'b1;
        obs_sp       = short_pay;
        obs_rem      = int'(remaining);
        change_valid = 1'b0;
      end
    end
    change_valid = 1'b0;
    coin_ack     = 1'b0;
    hopper_ready = 1'b1;
    checks++;
    if (!obs_done) begin
      errors++;
      $display("FAIL payout_timeout amt=%0d: done never seen, required done within budget", amt);
    end
    $display("payout amt=%0d coins=%0d cycles=%0d short_pay=%0b remaining=%0d",
             amt, obs_q.size(), obs_cycles, obs_sp, obs_rem);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({eject_20, eject_10, eject_5, busy, done, short_pay, error, remaining} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b error=%b remaining=%0d, required all 0",
               busy, done, error, remaining);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b, required 0", busy);
    end
    $display("test_reset done");
  endtask

  // Directed spec case: 45c with immediate acks.
  task automatic test_greedy();
    int exp_q[$] = '{20, 20, 5};
    run_payout(45, 1, 0, 1'b0, 1'b0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL greedy45_count: got %0d coins, required %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] != exp_q[i]) begin
          errors++;
          $display("FAIL greedy45_coin%0d: got %0d, required %0d", i, obs_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (obs_sp !== 1'b0 || obs_rem != 0) begin
      errors++;
      $display("FAIL greedy45_end: short_pay=%b remaining=%0d, required 0 and 0", obs_sp, obs_rem);
    end
    // Load cycle + 3 cycles per coin + the final SELECT.
    checks++;
    if (obs_cycles != 2 + 3 * 3) begin
      errors++;
      $display("FAIL greedy45_latency: done after %0d cycles, required %0d", obs_cycles, 11);
    end
  endtask

  task automatic test_zero();
    run_payout(0, 1, 0, 1'b0, 1'b0);
    checks++;
    if (obs_q.size() != 0 || obs_cycles != 2 || obs_sp !== 1'b0 || obs_rem != 0) begin
      errors++;
      $display("FAIL zero_amt: coins=%0d cycles=%0d short_pay=%b remaining=%0d, required 0,2,0,0",
               obs_q.size(), obs_cycles, obs_sp, obs_rem);
    end
  endtask

  task automatic test_stall();
    int exp_q[$] = '{20, 10, 5};
    run_payout(35, 1, 10, 1'b0, 1'b0);
    checks++;
    if (obs_q.size() != 3 || obs_q[0] != exp_q[0] || obs_q[1] != exp_q[1] || obs_q[2] != exp_q[2]) begin
      errors++;
      $display("FAIL stall35_seq: got %0d coins first=%0d, required 20,10,5",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : -1);
    end
    // First eject can only appear once hopper_ready rises at cycle 10.
    checks++;
    if (obs_cycles < 10 + 3 * 3) begin
      errors++;
      $display("FAIL stall35_latency: done after %0d cycles, required at least 19", obs_cycles);
    end
  endtask

  task automatic test_short();
    run_payout(7, 1, 0, 1'b0, 1'b0);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] != 5) begin
      errors++;
      $display("FAIL short7_seq: got %0d coins, required one 5c", obs_q.size());
    end
    checks++;
    if (obs_sp !== 1'b1 || obs_rem != 2) begin
      errors++;
      $display("FAIL short7_end: short_pay=%b remaining=%0d, required 1 and 2", obs_sp, obs_rem);
    end
  endtask

  task automatic test_timeout();
    bit seen = 1'b0;
    @(negedge clk);
    change_valid = 1'b1;
    change_amt   = 8'd20;
    hopper_ready = 1'b1;
    @(negedge clk);
    change_valid = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (eject_20) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL timeout_eject: eject_20 never seen, required one");
    end
    repeat (TIMEOUT) @(negedge clk);
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: error=%b after %0d wait cycles, required 0", error, TIMEOUT - 1);
    end
    @(negedge clk);
    checks++;
    if (error !== 1'b1 || remaining !== 8'd20 || busy !== 1'b1 || eject_20 !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fault: error=%b remaining=%0d busy=%b ej20=%b, required 1,20,1,0",
               error, remaining, busy, eject_20);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL timeout_hold: error=%b, required 1 until cleared", error);
    end
    clear_fault = 1'b1;
    @(negedge clk);
    clear_fault = 1'b0;
    checks++;
    if (error !== 1'b0 || busy !== 1'b0 || remaining !== 8'd20) begin
      errors++;
      $display("FAIL timeout_clear: error=%b busy=%b remaining=%0d, required 0,0,20",
               error, busy, remaining);
    end
    $display("test_timeout done");
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    @(negedge clk);
    change_valid = 1'b1;
    change_amt   = 8'd30;
    hopper_ready = 1'b1;
    @(negedge clk);
    change_valid = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (eject_20) seen = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (!seen || {eject_20, eject_10, eject_5, busy, done, short_pay, error, remaining} !== '0) begin
      errors++;
      $display("FAIL reset_mid: seen=%b busy=%b remaining=%0d, required eject then all 0 at once",
               seen, busy, remaining);
    end
    @(negedge clk);
    reset_n  = 1'b1;
    coin_ack = 1'b1;
    @(negedge clk);
    coin_ack = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || remaining !== '0 || eject_20 || eject_10 || eject_5) begin
        errors++;
        $display("FAIL reset_late_ack: busy=%b remaining=%0d, required idle with 0", busy, remaining);
      end
    end
    $display("test_reset_mid done");
  endtask

  // Back-to-back random payouts vs. arithmetic greedy model.
  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      int amt = $urandom_range(0, 255);
      int exp_q[$];
      int r = amt;
      for (int k = 0; k < amt / 20; k++) exp_q.push_back(20);
      r = amt % 20;
      for (int k = 0; k < r / 10; k++) exp_q.push_back(10);
      r = r % 10;
      for (int k = 0; k < r / 5; k++) exp_q.push_back(5);
      r = r % 5;
      run_payout(amt, 4, $urandom_range(0, 5), 1'b1, 1'b1);
      checks++;
      if (obs_q != exp_q) begin
        errors++;
        $display("FAIL random_seq amt=%0d: got %0d coins, required %0d", amt, obs_q.size(), exp_q.size());
      end
      checks++;
      if (obs_rem != r || obs_sp !== (r != 0)) begin
        errors++;
        $display("FAIL random_end amt=%0d: remaining=%0d short_pay=%b, required %0d and %0b",
                 amt, obs_rem, obs_sp, r, (r != 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_greedy();
    test_zero();
    test_stall();
    test_short();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
